// File: rtl/if_id_pipe_pkg.sv
// if_id_pipe_pkg: shared CPU constants and the fetch-side halt FSM states
package if_id_pipe_pkg;
    localparam int CPU_WIDTH = 16;
    localparam int OP_W = 4;
    localparam int CPU_CNT_W = 8;
    localparam logic [OP_W-1:0] CPU_HALT_OP = 4'b1111;
    localparam logic [CPU_WIDTH-1:0] CPU_NOP = 16'h0000;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } halt_state_t;
endpackage

// File: rtl/if_halt_fsm.sv
// if_halt_fsm: tracks a fetched HALT through decode and drives the sticky PC power-freeze
module if_halt_fsm
    import if_id_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_hold,
    input  logic i_halt_load,
    output logic o_run,
    output logic o_halted,
    output logic o_power_freeze
);
    halt_state_t r_state, w_next;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= RUN;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (i_flush) w_next = RUN;
        else if (r_state == RUN && i_halt_load) w_next = HALT_PEND;
        else if (r_state == HALT_PEND && !i_hold) w_next = HALTED;
    end

    assign o_run = r_state == RUN;
    assign o_halted = r_state == HALTED;
    // a flush must always let the PC load its redirect target
    assign o_power_freeze = o_halted & ~i_flush;
endmodule

// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register with structural bubbles, hazard hold,
// flush, halt detection and a saturating bubble counter
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter logic [OP_W-1:0] HALT_OP = CPU_HALT_OP,
    parameter logic [WIDTH-1:0] NOP = CPU_NOP,
    parameter int CNT_W = CPU_CNT_W
) (
    input  logic             clk,
    input  logic             rest,
    input  logic [WIDTH-1:0] MemResult_IF,
    input  logic [WIDTH-1:0] AddressPlus2_IF,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             PCFreze_HD,
    input  logic             brTaken,
    input  logic             Jump,
    output logic [WIDTH-1:0] Instr_ID,
    output logic [WIDTH-1:0] PCPlus2_ID,
    output logic             Valid_ID,
    output logic             PCFreze_SH,
    output logic             PowerFrezePC_SH,
    output logic             Halted,
    output logic [CNT_W-1:0] BubbleCount
);
    logic [WIDTH-1:0] r_instr, r_pc;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic w_sh, w_fl, w_run, w_bubble, w_count, w_halt_load;

    assign w_sh = MemRead_MEM | MemWrite_MEM;
    assign w_fl = brTaken | Jump;
    // flush beats hold; hold beats both the halt bubble and the structural bubble
    assign w_bubble = w_fl | (~PCFreze_HD & (~w_run | w_sh));
    assign w_count = w_fl | (~PCFreze_HD & w_run & w_sh);
    assign w_halt_load = ~w_fl & ~PCFreze_HD & w_run & ~w_sh
                       & (MemResult_IF[WIDTH-1 -: OP_W] == HALT_OP);

    if_halt_fsm u_fsm (
        .clk           (clk),
        .rst           (rest),
        .i_flush       (w_fl),
        .i_hold        (PCFreze_HD),
        .i_halt_load   (w_halt_load),
        .o_run         (w_run),
        .o_halted      (Halted),
        .o_power_freeze(PowerFrezePC_SH)
    );

    always_ff @(posedge clk or posedge rest)
        if (rest) begin
            r_instr <= NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (w_bubble) begin
            r_instr <= NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!PCFreze_HD) begin
            r_instr <= MemResult_IF;
            r_pc    <= AddressPlus2_IF;
            r_valid <= 1'b1;
        end

    always_ff @(posedge clk or posedge rest)
        if (rest) r_cnt <= '0;
        else if (w_count && r_cnt != '1) r_cnt <= r_cnt + 1'b1;

    assign PCFreze_SH  = w_sh;
    assign Instr_ID    = r_instr;
    assign PCPlus2_ID  = r_pc;
    assign Valid_ID    = r_valid;
    assign BubbleCount = r_cnt;
endmodule
